// File: rtl/iq_power_avg.sv
// Mean |x|^2 = I^2 + Q^2 over non-overlapping windows of 2^LOG2_N accepted samples.
// Four-stage pipeline: capture, square, sum, accumulate; one result pulse per window.
module iq_power_avg #(
  parameter int unsigned DW     = 16,
  parameter int unsigned LOG2_N = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [DW-1:0] i_i,
  input  logic [DW-1:0] q_i,
  output logic [31:0]   power_o,
  output logic          valid_o
);

  localparam int unsigned SqW  = 2 * DW - 1;
  localparam int unsigned SumW = 2 * DW;
  localparam int unsigned AccW = SumW + LOG2_N;

  localparam logic [LOG2_N-1:0] LastIdx = '1;
  localparam logic [LOG2_N-1:0] CntOne  = LOG2_N'(1);

  // Stage 0: sample capture and window position
  logic [LOG2_N-1:0]     cnt;
  logic                  s0_valid;
  logic                  s0_last;
  logic signed [DW-1:0]  s0_i;
  logic signed [DW-1:0]  s0_q;

  // Stage 1: squares
  logic                  s1_valid;
  logic                  s1_last;
  logic [SqW-1:0]        s1_ii;
  logic [SqW-1:0]        s1_qq;
  logic signed [SumW-1:0] prod_ii;
  logic signed [SumW-1:0] prod_qq;

  // Stage 2: instantaneous power
  logic                  s2_valid;
  logic                  s2_last;
  logic [SumW-1:0]       s2_sum;

  // Stage 3: window accumulator and result
  logic [AccW-1:0]       acc;
  logic [AccW-1:0]       acc_sum;
  logic [AccW-1:0]       acc_d;
  logic [31:0]           power_d;
  logic                  valid_d;

  // Control flags carry reset and abort; data registers only load under their valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (clr_i) begin
      cnt      <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s0_valid <= valid_i;
      s0_last  <= valid_i && (cnt == LastIdx);
      if (valid_i) begin
        cnt <= cnt + CntOne;
      end
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      s0_i <= i_i;
      s0_q <= q_i;
    end
    if (s0_valid) begin
      s1_ii <= SqW'(prod_ii);
      s1_qq <= SqW'(prod_qq);
    end
    if (s1_valid) begin
      s2_sum <= SumW'(s1_ii) + SumW'(s1_qq);
    end
  end

  // Square of a full-scale negative sample is 2^(2*DW-2), which fits SqW bits unsigned.
  always_comb begin
    prod_ii = SumW'(s0_i) * SumW'(s0_i);
    prod_qq = SumW'(s0_q) * SumW'(s0_q);
  end

  always_comb begin
    acc_sum = acc + AccW'(s2_sum);
    acc_d   = acc;
    power_d = power_o;
    valid_d = 1'b0;
    if (s2_valid) begin
      if (s2_last) begin
        power_d = acc_sum[LOG2_N +: 32];
        valid_d = 1'b1;
        acc_d   = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Abort keeps the last published result on power_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      power_o <= '0;
      valid_o <= 1'b0;
    end else if (clr_i) begin
      acc     <= '0;
      valid_o <= 1'b0;
    end else begin
      acc     <= acc_d;
      power_o <= power_d;
      valid_o <= valid_d;
    end
  end

endmodule
